// File: rtl/rlbp_wb_serializer.sv
// Wishbone-mapped parallel-to-serial engine: CTRL/STATUS/TXDATA/COUNT registers,
// a TX FIFO and a divided-rate shifter with MSB/LSB-first framing.
module rlbp_wb_serializer #(
  parameter int         DATA_W     = 8,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] BASE_NIB   = 4'h3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        ser_data_o,
  output logic        ser_valid_o,
  output logic        ser_frame_o,
  output logic        irq_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  logic              ack_r, ser_data_r, ser_valid_r, ser_frame_r, irq_r;
  logic [31:0]       dat_r, rdata_s;
  logic              enable_r, lsb_first_r, irq_en_r, ovf_r;
  logic [7:0]        clk_div_r;
  logic              enable_nx_s, lsb_first_nx_s, irq_en_nx_s;
  logic [7:0]        clk_div_nx_s;
  logic              hit_s, acc_s, wr_s, ctrl_wr_s, stat_wr_s, push_req_s, flush_s;
  logic [1:0]        idx_s;
  logic [DATA_W-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r, wr_ptr_r;
  logic [LVL_W-1:0]  level_r, level_nx_s;
  logic              empty_s, full_s, push_ok_s, ovf_set_s, pop_s;
  state_t            state_r, state_c_s, state_nx_s;
  logic [DATA_W-1:0] shreg_r, shreg_c_s, shreg_nx_s;
  logic [BIT_W-1:0]  bit_cnt_r, bit_c_s, bit_nx_s;
  logic [7:0]        div_cnt_r, div_c_s, div_nx_s;
  logic              lsb_r, lsb_nx_s, start_req_s, start_s, done_s, count_inc_s;
  logic              ser_data_nx_s, irq_nx_s;
  logic [15:0]       count_r;

  assign wbs_ack_o   = ack_r;
  assign wbs_dat_o   = dat_r;
  assign ser_data_o  = ser_data_r;
  assign ser_valid_o = ser_valid_r;
  assign ser_frame_o = ser_frame_r;
  assign irq_o       = irq_r;

  // Bus decode: an access takes effect only on the edge that raises ack.
  always_comb begin
    hit_s      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:28] == BASE_NIB);
    acc_s      = hit_s & ~ack_r;
    idx_s      = wbs_adr_i[3:2];
    wr_s       = acc_s & wbs_we_i & wbs_sel_i[0];
    ctrl_wr_s  = wr_s & (idx_s == 2'd0);
    stat_wr_s  = wr_s & (idx_s == 2'd1);
    push_req_s = wr_s & (idx_s == 2'd2);
    flush_s    = ctrl_wr_s & wbs_dat_i[3];
    empty_s    = (level_r == LVL_ZERO);
    full_s     = (level_r == LVL_FULL);
  end

  // Read data mux over the pre-edge register state.
  always_comb begin
    rdata_s = 32'd0;
    case (idx_s)
      2'd0: rdata_s = {16'd0, clk_div_r, 5'd0, irq_en_r, lsb_first_r, enable_r};
      2'd1: begin
        rdata_s[0]          = (state_r == SHIFT);
        rdata_s[1]          = full_s;
        rdata_s[2]          = empty_s;
        rdata_s[3]          = ovf_r;
        rdata_s[8 +: LVL_W] = level_r;
      end
      2'd3: rdata_s = {16'd0, count_r};
      default: rdata_s = 32'd0;
    endcase
  end

  // CTRL next value; clk_div additionally needs byte lane 1.
  always_comb begin
    enable_nx_s    = enable_r;
    lsb_first_nx_s = lsb_first_r;
    irq_en_nx_s    = irq_en_r;
    clk_div_nx_s   = clk_div_r;
    if (ctrl_wr_s) begin
      enable_nx_s    = wbs_dat_i[0];
      lsb_first_nx_s = wbs_dat_i[1];
      irq_en_nx_s    = wbs_dat_i[2];
      if (wbs_sel_i[1]) clk_div_nx_s = wbs_dat_i[15:8];
      else              clk_div_nx_s = clk_div_r;
    end else begin
      clk_div_nx_s = clk_div_r;
    end
  end

  // Shifter sequencing without the flush/load overrides.
  always_comb begin
    state_c_s   = state_r;
    shreg_c_s   = shreg_r;
    bit_c_s     = bit_cnt_r;
    div_c_s     = div_cnt_r;
    start_req_s = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable_r & ~empty_s) start_req_s = 1'b1;
        else                     state_c_s   = IDLE;
      end
      SHIFT: begin
        if (div_cnt_r >= clk_div_r) begin
          div_c_s = 8'd0;
          if (bit_cnt_r == BIT_LAST) begin
            done_s      = 1'b1;
            state_c_s   = IDLE;
            start_req_s = enable_r & ~empty_s;
          end else begin
            bit_c_s   = bit_cnt_r + BIT_ONE;
            shreg_c_s = lsb_r ? (shreg_r >> 1'b1) : (shreg_r << 1'b1);
          end
        end else begin
          div_c_s = div_cnt_r + 8'd1;
        end
      end
      default: state_c_s = IDLE;
    endcase
  end

  // Flush beats everything; a load (first or gapless) pops the FIFO head.
  always_comb begin
    start_s     = start_req_s & ~flush_s;
    pop_s       = start_s;
    count_inc_s = done_s & ~flush_s;
    if (flush_s) begin
      state_nx_s = IDLE;
      shreg_nx_s = shreg_r;
      bit_nx_s   = bit_cnt_r;
      div_nx_s   = div_cnt_r;
      lsb_nx_s   = lsb_r;
    end else if (start_s) begin
      state_nx_s = SHIFT;
      shreg_nx_s = fifo_mem_r[rd_ptr_r];
      bit_nx_s   = {BIT_W{1'b0}};
      div_nx_s   = 8'd0;
      lsb_nx_s   = lsb_first_r;
    end else begin
      state_nx_s = state_c_s;
      shreg_nx_s = shreg_c_s;
      bit_nx_s   = bit_c_s;
      div_nx_s   = div_c_s;
      lsb_nx_s   = lsb_r;
    end
    push_ok_s = push_req_s & (~full_s | pop_s);
    ovf_set_s = push_req_s & ~push_ok_s;
    if (flush_s) level_nx_s = LVL_ZERO;
    else         level_nx_s = level_r + LVL_W'(push_ok_s) - LVL_W'(pop_s);
    ser_data_nx_s = (state_nx_s == SHIFT) &
                    (lsb_nx_s ? shreg_nx_s[0] : shreg_nx_s[DATA_W-1]);
    irq_nx_s = irq_en_nx_s & (level_nx_s == LVL_ZERO) & (state_nx_s == IDLE);
  end

  // FIFO storage; stale entries are unreachable once the pointers reset.
  always_ff @(posedge wb_clk_i) begin
    if (push_ok_s) fifo_mem_r[wr_ptr_r] <= wbs_dat_i[DATA_W-1:0];
  end

  // Registers, pointers, shifter state and registered outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_r <= 1'b0;  dat_r <= 32'd0;
      enable_r <= 1'b0;  lsb_first_r <= 1'b0;  irq_en_r <= 1'b0;  clk_div_r <= 8'd0;
      ovf_r <= 1'b0;  level_r <= LVL_ZERO;
      rd_ptr_r <= {PTR_W{1'b0}};  wr_ptr_r <= {PTR_W{1'b0}};
      state_r <= IDLE;  shreg_r <= {DATA_W{1'b0}};  bit_cnt_r <= {BIT_W{1'b0}};
      div_cnt_r <= 8'd0;  lsb_r <= 1'b0;  count_r <= 16'd0;
      ser_data_r <= 1'b0;  ser_valid_r <= 1'b0;  ser_frame_r <= 1'b0;  irq_r <= 1'b0;
    end else begin
      ack_r <= acc_s;
      dat_r <= (acc_s & ~wbs_we_i) ? rdata_s : 32'd0;
      enable_r    <= enable_nx_s;
      lsb_first_r <= lsb_first_nx_s;
      irq_en_r    <= irq_en_nx_s;
      clk_div_r   <= clk_div_nx_s;
      if (stat_wr_s & wbs_dat_i[3]) ovf_r <= 1'b0;
      else if (ovf_set_s)           ovf_r <= 1'b1;
      level_r <= level_nx_s;
      if (flush_s) begin
        rd_ptr_r <= {PTR_W{1'b0}};
        wr_ptr_r <= {PTR_W{1'b0}};
      end else begin
        if (pop_s)     rd_ptr_r <= rd_ptr_r + PTR_ONE;
        if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      state_r   <= state_nx_s;
      shreg_r   <= shreg_nx_s;
      bit_cnt_r <= bit_nx_s;
      div_cnt_r <= div_nx_s;
      lsb_r     <= lsb_nx_s;
      if (count_inc_s) count_r <= count_r + 16'd1;
      ser_data_r  <= ser_data_nx_s;
      ser_valid_r <= (state_nx_s == SHIFT);
      ser_frame_r <= start_s;
      irq_r       <= irq_nx_s;
    end
  end

endmodule

// File: tb/tb_rlbp_wb_serializer.sv
// Directed bench for rlbp_wb_serializer: a queue-based frame model checked every
// cycle, plus literal expectations for register reads and captured bit streams.
module tb_rlbp_wb_serializer;
  localparam int         DATA_W     = 8;
  localparam int         FIFO_DEPTH = 4;
  localparam logic [3:0] BASE_NIB   = 4'h3;
  localparam logic [31:0] A_CTRL = 32'h3000_0000, A_STAT = 32'h3000_0004;
  localparam logic [31:0] A_TX   = 32'h3000_0008, A_CNT  = 32'h3000_000C;

  logic        wb_clk_i = 1'b0, wb_rst_i = 1'b1;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = 32'd0, wbs_dat_i = 32'd0;
  logic        wbs_ack_o, ser_data_o, ser_valid_o, ser_frame_o, irq_o;
  logic [31:0] wbs_dat_o;

  always #5 wb_clk_i = ~wb_clk_i;

  rlbp_wb_serializer #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .BASE_NIB(BASE_NIB)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i),
    .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o), .ser_data_o(ser_data_o),
    .ser_valid_o(ser_valid_o), .ser_frame_o(ser_frame_o), .irq_o(irq_o));

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: FIFO as a queue, the active frame as (word, cycle index, divider).
  bit                m_live = 1'b0, m_ack = 1'b0, m_rd = 1'b0, m_frame = 1'b0;
  logic [31:0]       m_rdata = 32'd0;
  bit                m_en = 1'b0, m_lsb = 1'b0, m_irqen = 1'b0, m_ovf = 1'b0;
  logic [7:0]        m_div = 8'd0;
  logic [15:0]       m_count = 16'd0;
  logic [DATA_W-1:0] q[$];
  bit                m_busy = 1'b0, m_flsb = 1'b0;
  logic [DATA_W-1:0] m_word = '0;
  int                m_t = 0, m_fdiv = 0;

  initial begin : model
    bit hit, acc, wr, flush, done, pop;
    logic [1:0] idx;
    logic [31:0] rd;
    forever begin
      @(posedge wb_clk_i);
      if (wb_rst_i) begin
        m_live = 1'b1; m_ack = 1'b0; m_rd = 1'b0; m_frame = 1'b0; m_rdata = 32'd0;
        m_en = 1'b0; m_lsb = 1'b0; m_irqen = 1'b0; m_ovf = 1'b0; m_div = 8'd0;
        m_count = 16'd0; q.delete(); m_busy = 1'b0; m_t = 0;
      end else begin
        hit = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:28] == BASE_NIB);
        acc = hit && !m_ack;
        idx = wbs_adr_i[3:2];
        wr  = acc && wbs_we_i && wbs_sel_i[0];
        case (idx)
          2'd0: rd = {16'd0, m_div, 5'd0, m_irqen, m_lsb, m_en};
          2'd1: rd = (32'(q.size()) << 8) | {28'd0, m_ovf, q.size() == 0,
                                              q.size() == FIFO_DEPTH, m_busy};
          2'd3: rd = {16'd0, m_count};
          default: rd = 32'd0;
        endcase
        m_ack = acc; m_rd = acc && !wbs_we_i; m_rdata = rd;
        flush = wr && idx == 2'd0 && wbs_dat_i[3];
        done  = m_busy && (m_t == DATA_W * (m_fdiv + 1) - 1);
        pop   = !flush && (!m_busy || done) && m_en && q.size() > 0;
        m_frame = 1'b0;
        if (flush) begin
          q.delete(); m_busy = 1'b0;
        end else begin
          if (done) begin m_count = m_count + 16'd1; m_busy = 1'b0; end
          else if (m_busy) m_t++;
          if (pop) begin
            m_word = q.pop_front(); m_busy = 1'b1; m_t = 0;
            m_flsb = m_lsb; m_fdiv = int'(m_div); m_frame = 1'b1;
          end
        end
        if (wr && idx == 2'd2) begin
          if (q.size() < FIFO_DEPTH) q.push_back(wbs_dat_i[DATA_W-1:0]);
          else m_ovf = 1'b1;
        end
        if (wr && idx == 2'd1 && wbs_dat_i[3]) m_ovf = 1'b0;
        if (wr && idx == 2'd0) begin
          m_en = wbs_dat_i[0]; m_lsb = wbs_dat_i[1]; m_irqen = wbs_dat_i[2];
          if (wbs_sel_i[1]) m_div = wbs_dat_i[15:8];
        end
      end
    end
  end

  initial begin : compare
    int k;
    bit exp_data;
    forever begin
      @(negedge wb_clk_i);
      if (m_live) begin
        k = m_t / (m_fdiv + 1);
        exp_data = m_busy && (m_flsb ? m_word[k] : m_word[DATA_W-1-k]);
        chk("ack", wbs_ack_o, m_ack);
        chk("ser_valid", ser_valid_o, m_busy);
        chk("ser_frame", ser_frame_o, m_frame);
        chk("ser_data", ser_data_o, exp_data);
        chk("irq", irq_o, m_irqen && q.size() == 0 && !m_busy);
        if (m_ack && m_rd) chk("rdata", wbs_dat_o, m_rdata);
      end
    end
  end

  task automatic wb_xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         output logic [31:0] rdata);
    bit got = 1'b0;
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = 4'hF;
    rdata = 32'd0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin got = 1'b1; rdata = wbs_dat_o; end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    chk("bus_ack_seen", got, 1'b1);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] unused;
    wb_xfer(1'b1, adr, dat, unused);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] v;
    wb_xfer(1'b0, adr, 32'd0, v);
    chk(name, v, exp);
  endtask

  // Waits for a frame to appear, then samples n consecutive cycles.
  task automatic capture(input int n, output logic [63:0] bits, output int frames,
                         output int valids);
    bit seen = 1'b0;
    bits = 64'd0; frames = 0; valids = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge wb_clk_i);
      if (ser_valid_o) seen = 1'b1;
    end
    chk("frame_seen", seen, 1'b1);
    for (int i = 0; i < n && seen; i++) begin
      if (i > 0) @(negedge wb_clk_i);
      bits = {bits[62:0], ser_data_o};
      frames += int'(ser_frame_o);
      valids += int'(ser_valid_o);
    end
  endtask

  task automatic wait_idle(input string name);
    bit idle = 1'b0;
    for (int i = 0; i < 60 && !idle; i++) begin
      @(negedge wb_clk_i);
      if (!ser_valid_o) idle = 1'b1;
    end
    chk(name, idle, 1'b1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [63:0] bits;
    int frames, valids;
    repeat (2) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;

    rd_chk("reset_ctrl", A_CTRL, 32'h0);
    @(posedge wb_clk_i); #1;
    chk("ack_one_cycle", wbs_ack_o, 1'b0);
    rd_chk("reset_status", A_STAT, 32'h4);
    rd_chk("reset_count", A_CNT, 32'h0);
    rd_chk("txdata_reads_0", A_TX, 32'h0);

    wr(A_CTRL, 32'h0001);
    wr(A_TX, 32'h0000_00A5);
    capture(8, bits, frames, valids);
    chk("msb_bits_a5", bits[7:0], 8'hA5);
    chk("msb_frames", frames, 1);
    chk("msb_valid_cycles", valids, 8);
    rd_chk("count_after_a5", A_CNT, 32'h1);

    wr(A_CTRL, 32'h0203);
    rd_chk("ctrl_readback", A_CTRL, 32'h0203);
    wr(A_TX, 32'h01);
    fork
      capture(48, bits, frames, valids);
      wr(A_TX, 32'h80);
    join
    chk("lsb_bits_gapless", bits[47:0], 48'hE000_0000_0007);
    chk("lsb_frames", frames, 2);
    chk("lsb_valid_cycles", valids, 48);
    rd_chk("count_after_lsb", A_CNT, 32'h3);

    wr(A_CTRL, 32'h0000);
    for (int i = 0; i < FIFO_DEPTH + 1; i++) wr(A_TX, 32'h11 + 32'(i));
    rd_chk("status_overflow", A_STAT, 32'h40A);
    wr(A_STAT, 32'h8);
    rd_chk("status_ovf_cleared", A_STAT, 32'h402);

    wr(A_CTRL, 32'h0005);
    wr(A_CTRL, 32'h0004);
    wait_idle("enable_clear_finishes");
    rd_chk("status_after_disable", A_STAT, 32'h300);
    rd_chk("count_after_disable", A_CNT, 32'h4);
    wr(A_CTRL, 32'h000C);
    rd_chk("status_after_flush", A_STAT, 32'h004);
    rd_chk("ctrl_after_flush", A_CTRL, 32'h0004);
    @(negedge wb_clk_i);
    chk("irq_idle_empty", irq_o, 1'b1);

    wr(A_CTRL, 32'h0001);
    wr(A_TX, 32'hFF);
    capture(3, bits, frames, valids);
    chk("pre_reset_bits", bits[2:0], 3'b111);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("reset_mid_frame_valid", ser_valid_o, 1'b0);
    rd_chk("post_reset_ctrl", A_CTRL, 32'h0);
    rd_chk("post_reset_status", A_STAT, 32'h4);
    rd_chk("post_reset_count", A_CNT, 32'h0);
    repeat (4) @(posedge wb_clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
